// File: rtl/dma_pkg.sv
// Shared DMA types, bus constants and burst-sizing helpers used by the streamer instances.
package dma_pkg;

   localparam int DATA_BUS_WIDTH     = 64;
   localparam int BYTES_PER_BEAT     = DATA_BUS_WIDTH / 8;
   localparam int BEAT_SIZE          = $clog2(BYTES_PER_BEAT);
   localparam int AXI_4K_BYTES       = 4096;
   localparam int DMA_FIFO_DEPTH     = 16;
   localparam int DMA_MAX_BEAT_BURST = 256;
   localparam bit DMA_MAX_BURST_EN   = 1'b1;
   localparam int FIFO_SZ_W          = $clog2(DMA_FIFO_DEPTH) + 1;

   typedef logic [FIFO_SZ_W-1:0] fifo_sz_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_CALC  = 3'd2,
      ST_REQ   = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } dma_strm_st_t;

   typedef enum logic [1:0] {
      DMA_NO_ERR        = 2'd0,
      DMA_UNALIGNED_ERR = 2'd1,
      DMA_AXI_RD_ERR    = 2'd2,
      DMA_AXI_WR_ERR    = 2'd3
   } dma_err_t;

   typedef struct packed {
      logic [31:0] src_addr;
      logic [31:0] dst_addr;
      logic [31:0] num_bytes;
   } s_dma_desc_t;

   typedef struct packed {
      logic [31:0]               addr;
      logic [7:0]                alen;
      logic [2:0]                size;
      logic [BYTES_PER_BEAT-1:0] strb;
      logic                      valid;
   } s_dma_axi_req_t;

   typedef struct packed {
      logic ready;
   } s_dma_axi_resp_t;

   typedef struct packed {
      logic [31:0] addr;
      dma_err_t    code;
      logic        valid;
   } s_dma_error_t;

   // Largest legal burst: limited by remaining beats, burst cap, FIFO depth and the 4KB page end.
   function automatic logic [31:0] dma_burst_beats(input logic [31:0] rem_beats,
                                                   input logic [31:0] max_beats,
                                                   input logic [31:0] addr);
      logic [31:0] page_beats;
      logic [31:0] beats;
      page_beats = (32'(AXI_4K_BYTES) - {20'd0, addr[11:0]}) >> BEAT_SIZE;
      beats      = (rem_beats < max_beats) ? rem_beats : max_beats;
      beats      = (beats < 32'(DMA_FIFO_DEPTH)) ? beats : 32'(DMA_FIFO_DEPTH);
      beats      = (beats < page_beats) ? beats : page_beats;
      return beats;
   endfunction

   function automatic logic [BYTES_PER_BEAT-1:0] dma_tail_strb(input logic [BEAT_SIZE-1:0] tail);
      logic [BYTES_PER_BEAT-1:0] one;
      one = {{(BYTES_PER_BEAT-1){1'b0}}, 1'b1};
      return (tail == '0) ? '1 : ((one << tail) - one);
   endfunction

endpackage

// File: rtl/dma_streamer.sv
// Splits one DMA descriptor into 4KB-safe AXI burst requests, throttled by FIFO level and
// the outstanding-burst budget, and reports completion or alignment errors.
module dma_streamer
   import dma_pkg::*;
#(
   parameter bit STREAM_WR = 1'b0,
   parameter int MAX_BEATS = DMA_MAX_BEAT_BURST,
   parameter int OUTST_W   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            dma_go_i,
   input  logic            dma_abort_i,
   input  s_dma_desc_t     desc_i,
   input  fifo_sz_t        fifo_lvl_i,
   output s_dma_axi_req_t  dma_axi_req_o,
   input  s_dma_axi_resp_t dma_axi_resp_i,
   input  logic            burst_done_i,
   output logic            done_o,
   output s_dma_error_t    error_o
);

   localparam int                 MAX_B     = DMA_MAX_BURST_EN ? MAX_BEATS : 1;
   localparam logic [OUTST_W-1:0] OUTST_MAX = {OUTST_W{1'b1}};
   localparam logic [OUTST_W-1:0] OUTST_ONE = {{(OUTST_W-1){1'b0}}, 1'b1};

   dma_strm_st_t           state_q, state_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            rem_q, rem_d;
   logic [BEAT_SIZE-1:0]   tail_q, tail_d;
   logic [OUTST_W-1:0]     outst_q, outst_d;
   logic                   abort_q, abort_d;
   logic                   done_q, done_d;
   s_dma_axi_req_t         req_q, req_d;
   s_dma_error_t           err_q, err_d;

   logic [31:0]            beats_s;
   logic                   hs_s;
   logic                   dec_s;
   logic                   abort_s;
   logic [31:0]            start_addr_s;

   // Outstanding-burst bookkeeping; a completion with nothing in flight is dropped.
   always_comb begin
      hs_s  = req_q.valid && dma_axi_resp_i.ready;
      dec_s = burst_done_i && (outst_q != '0);
      if (hs_s && !dec_s) begin
         outst_d = outst_q + OUTST_ONE;
      end else if (!hs_s && dec_s) begin
         outst_d = outst_q - OUTST_ONE;
      end else begin
         outst_d = outst_q;
      end
   end

   // Descriptor walk: alignment check, burst sizing, request hold and drain.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      tail_d       = tail_q;
      req_d        = req_q;
      err_d        = err_q;
      abort_s      = abort_q || dma_abort_i;
      abort_d      = abort_s;
      beats_s      = dma_burst_beats(rem_q, 32'(MAX_B), addr_q);
      start_addr_s = STREAM_WR ? desc_i.dst_addr : desc_i.src_addr;
      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (dma_go_i) begin
               state_d = ST_CHECK;
               err_d   = '0;
               addr_d  = start_addr_s;
               rem_d   = (desc_i.num_bytes >> BEAT_SIZE)
                         + {31'd0, |desc_i.num_bytes[BEAT_SIZE-1:0]};
               tail_d  = desc_i.num_bytes[BEAT_SIZE-1:0];
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (addr_q[BEAT_SIZE-1:0] != '0) begin
               err_d.addr  = addr_q;
               err_d.code  = DMA_UNALIGNED_ERR;
               err_d.valid = 1'b1;
               state_d     = ST_DONE;
            end else if (rem_q == 32'd0) begin
               state_d = ST_DONE;
            end else if (abort_s) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (abort_s) begin
               state_d = ST_DRAIN;
            end else if ((32'(fifo_lvl_i) < beats_s) || (outst_q == OUTST_MAX)) begin
               state_d = ST_CALC;
            end else begin
               state_d     = ST_REQ;
               req_d.addr  = addr_q;
               req_d.alen  = 8'(beats_s - 32'd1);
               req_d.size  = 3'(BEAT_SIZE);
               req_d.strb  = (rem_q == beats_s) ? dma_tail_strb(tail_q) : '1;
               req_d.valid = 1'b1;
            end
         end
         ST_REQ: begin
            // addr_q/rem_q are frozen here, so beats_s still matches the issued request.
            if (hs_s) begin
               req_d.valid = 1'b0;
               addr_d      = addr_q + (beats_s << BEAT_SIZE);
               rem_d       = rem_q - beats_s;
               state_d     = ((rem_d == 32'd0) || abort_s) ? ST_DRAIN : ST_CALC;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (outst_d == '0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d     = ST_IDLE;
            req_d.valid = 1'b0;
         end
      endcase
      done_d = (state_d == ST_DONE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         addr_q  <= 32'd0;
         rem_q   <= 32'd0;
         tail_q  <= '0;
         outst_q <= '0;
         abort_q <= 1'b0;
         done_q  <= 1'b0;
         req_q   <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         tail_q  <= tail_d;
         outst_q <= outst_d;
         abort_q <= abort_d;
         done_q  <= done_d;
         req_q   <= req_d;
         err_q   <= err_d;
      end
   end

   assign dma_axi_req_o = req_q;
   assign done_o        = done_q;
   assign error_o       = err_q;

endmodule

// File: tb/tb_dma_streamer.sv
// Randomized scoreboard bench for the read-side dma_streamer against a burst-splitting reference model.
module tb_dma_streamer;
   import dma_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            dma_go_i = 1'b0;
   logic            dma_abort_i = 1'b0;
   s_dma_desc_t     desc_i = '0;
   fifo_sz_t        fifo_lvl_i = 5'd16;
   s_dma_axi_req_t  dma_axi_req_o;
   s_dma_axi_resp_t dma_axi_resp_i = '0;
   logic            burst_done_i = 1'b0;
   logic            done_o;
   s_dma_error_t    error_o;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  alen;
      logic [7:0]  strb;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          pending = 0;
   longint      cyc = 0;
   longint      last_bd = 0;
   int          done_cnt = 0;
   bit          chk_lat = 1'b0;
   int          ready_mode = 1;
   int          lvl_mode = 0;
   int          lvl_fix = 16;
   logic [34:0] exp_err = '0;

   dma_streamer #(.STREAM_WR(1'b0), .MAX_BEATS(256), .OUTST_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .dma_go_i(dma_go_i), .dma_abort_i(dma_abort_i),
      .desc_i(desc_i), .fifo_lvl_i(fifo_lvl_i), .dma_axi_req_o(dma_axi_req_o),
      .dma_axi_resp_i(dma_axi_resp_i), .burst_done_i(burst_done_i),
      .done_o(done_o), .error_o(error_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", name, got, want);
      end
   endtask

   // Reference: walk the descriptor in bursts that never exceed 16 beats nor cross 4KB.
   function automatic int model_push(input logic [31:0] a, input logic [31:0] n);
      int unsigned rem, beats, page, tail, addr, cnt;
      exp_t e;
      cnt = 0;
      if (a % 8 != 0) begin
         exp_err = {a, 2'd1, 1'b1};
         return 0;
      end
      exp_err = '0;
      addr = a;
      tail = n % 8;
      rem  = (n + 7) / 8;
      while (rem > 0) begin
         beats = rem;
         if (beats > 256) beats = 256;
         if (beats > 16) beats = 16;
         page = (4096 - (addr % 4096)) / 8;
         if (beats > page) beats = page;
         e.addr = addr;
         e.alen = 8'(beats - 1);
         e.strb = (rem == beats && tail != 0) ? 8'((1 << tail) - 1) : 8'hFF;
         exp_q.push_back(e);
         addr += beats * 8;
         rem  -= beats;
         cnt++;
      end
      return cnt;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Environment driver: ready, FIFO level and burst completions.
   initial forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
         0: dma_axi_resp_i.ready = 1'b0;
         1: dma_axi_resp_i.ready = 1'b1;
         default: dma_axi_resp_i.ready = ($urandom_range(0, 3) != 0);
      endcase
      if (lvl_mode == 0) fifo_lvl_i = fifo_sz_t'(lvl_fix);
      else fifo_lvl_i = ($urandom_range(0, 1) == 1) ? 5'd16 : fifo_sz_t'($urandom_range(4, 16));
      burst_done_i = 1'b0;
      if (pending > 0 && $urandom_range(0, 2) == 0) begin
         burst_done_i = 1'b1;
         pending--;
      end
   end

   // Monitor: pops the scoreboard on every handshake and checks hold/gating/done latency.
   initial begin
      s_dma_axi_req_t prev_req;
      bit             prev_ready;
      int             prev_lvl;
      exp_t           e;
      prev_req = '0;
      prev_ready = 1'b0;
      prev_lvl = 0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (dma_axi_req_o.valid && prev_req.valid && !prev_ready)
               chk("req_hold", 64'(dma_axi_req_o), 64'(prev_req));
            if (dma_axi_req_o.valid && !prev_req.valid)
               chk("lvl_gate", 64'(prev_lvl >= int'(dma_axi_req_o.alen) + 1), 64'd1);
            if (dma_axi_req_o.valid && dma_axi_resp_i.ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_req: got addr=0x%0h alen=%0d want no request",
                           dma_axi_req_o.addr, dma_axi_req_o.alen);
               end else begin
                  e = exp_q.pop_front();
                  chk("req_addr", 64'(dma_axi_req_o.addr), 64'(e.addr));
                  chk("req_alen", 64'(dma_axi_req_o.alen), 64'(e.alen));
                  chk("req_size", 64'(dma_axi_req_o.size), 64'd3);
                  chk("req_strb", 64'(dma_axi_req_o.strb), 64'(e.strb));
               end
               pending++;
            end
            if (burst_done_i) last_bd = cyc;
            if (done_o) begin
               done_cnt++;
               if (chk_lat) chk("done_lat", 64'(cyc - last_bd), 64'd1);
            end
         end
         prev_req   = dma_axi_req_o;
         prev_ready = dma_axi_resp_i.ready;
         prev_lvl   = int'(fifo_lvl_i);
      end
   end

   task automatic run_desc(input logic [31:0] a, input logic [31:0] n,
                           input bit do_abort, input int hold);
      int nb;
      bit got;
      nb = model_push(a, n);
      if (do_abort) begin
         while (exp_q.size() > 1) void'(exp_q.pop_back());
      end
      chk_lat = (nb > 0) && !do_abort;
      @(negedge clk);
      desc_i.src_addr  = a;
      desc_i.dst_addr  = ~a;
      desc_i.num_bytes = n;
      dma_go_i = 1'b1;
      @(negedge clk);
      dma_go_i = 1'b0;
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         chk("gate_hold", 64'(exp_q.size()), 64'(nb));
         lvl_fix = 16;
      end
      if (do_abort) begin
         got = 1'b0;
         for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk);
            if (dma_axi_req_o.valid) got = 1'b1;
         end
         chk("abort_valid_seen", 64'(got), 64'd1);
         dma_abort_i = 1'b1;
         repeat (5) @(negedge clk);
         ready_mode = 1;
      end
      got = 1'b0;
      for (int t = 0; t < 4000 && !got; t++) begin
         @(negedge clk);
         if (done_o) got = 1'b1;
      end
      chk("done_seen", 64'(got), 64'd1);
      chk("error_o", 64'(error_o), 64'(exp_err));
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      chk("pending_zero", 64'(pending), 64'd0);
      dma_abort_i = 1'b0;
      @(negedge clk);
      chk("done_pulse", 64'(done_o), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      logic [31:0] a, n;
      int d0;
      bit got;
      repeat (2) @(negedge clk);
      chk("rst_req", 64'(dma_axi_req_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_err", 64'(error_o), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_desc(32'h0000_1000, 32'd64, 1'b0, 0);
      run_desc(32'h0000_0FF0, 32'd64, 1'b0, 0);
      lvl_fix = 8;
      run_desc(32'h0000_0000, 32'd4096, 1'b0, 40);
      run_desc(32'h0000_1004, 32'd32, 1'b0, 0);
      run_desc(32'h0000_2000, 32'd20, 1'b0, 0);
      run_desc(32'h0000_2000, 32'd0, 1'b0, 0);
      ready_mode = 0;
      run_desc(32'h0000_0000, 32'd256, 1'b1, 0);

      ready_mode = 2;
      lvl_mode   = 1;
      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0: a = 32'(4096 - 8 * $urandom_range(1, 20));
            1, 2: a = 32'(8 * $urandom_range(0, 511));
            default: a = 32'($urandom_range(0, 4095));
         endcase
         a = a + 32'(4096 * $urandom_range(0, 3));
         n = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 16)) : 32'($urandom_range(17, 700));
         run_desc(a, n, 1'b0, 0);
      end

      ready_mode = 0;
      lvl_mode   = 0;
      lvl_fix    = 16;
      @(negedge clk);
      desc_i.src_addr  = 32'd0;
      desc_i.num_bytes = 32'd128;
      dma_go_i = 1'b1;
      @(negedge clk);
      dma_go_i = 1'b0;
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         if (dma_axi_req_o.valid) got = 1'b1;
      end
      chk("rst_mid_valid_seen", 64'(got), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_req", 64'(dma_axi_req_o), 64'd0);
      chk("rst_mid_done", 64'(done_o), 64'd0);
      d0 = done_cnt;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_mid_no_done", 64'(done_cnt), 64'(d0));
      chk("rst_mid_idle_req", 64'(dma_axi_req_o), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
